// File: rtl/csr_trap_unit_if.sv
// CSR access port: address/operation/operand from the core, read data and
// illegal-access flag back from the CSR unit.
interface csr_trap_unit_if #(
   parameter int XLEN = 32
);
   logic [11:0]     csr_addr;
   logic [1:0]      csr_op;
   logic [XLEN-1:0] csr_w_data;
   logic [XLEN-1:0] csr_r_data;
   logic            csr_illegal;

   modport master (
      output csr_addr, csr_op, csr_w_data,
      input  csr_r_data, csr_illegal
   );

   modport slave (
      input  csr_addr, csr_op, csr_w_data,
      output csr_r_data, csr_illegal
   );
endinterface

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with trap entry, mret return, interrupt pending
// detection and 64-bit cycle/instret counters.
module csr_trap_unit #(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
   input  logic            clock,
   input  logic            reset,
   csr_trap_unit_if.slave  csr_bus,
   input  logic            trap_en,
   input  logic [XLEN-1:0] trap_cause,
   input  logic [XLEN-1:0] trap_pc,
   input  logic [XLEN-1:0] trap_val,
   input  logic            mret_en,
   input  logic            retire_en,
   input  logic            ext_irq,
   input  logic            timer_irq,
   output logic            irq_pending,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc
);
   localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
   localparam logic [11:0] ADDR_MIE       = 12'h304;
   localparam logic [11:0] ADDR_MTVEC     = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
   localparam logic [11:0] ADDR_MEPC      = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
   localparam logic [11:0] ADDR_MTVAL     = 12'h343;
   localparam logic [11:0] ADDR_MIP       = 12'h344;
   localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
   localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
   localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

   typedef enum logic [1:0] {
      OP_NONE  = 2'b00,
      OP_WRITE = 2'b01,
      OP_SET   = 2'b10,
      OP_CLEAR = 2'b11
   } csr_op_e;

   csr_op_e           op;
   logic              mapped;
   logic [XLEN-1:0]   old_val;
   logic [XLEN-1:0]   new_val;
   logic              wr_en;

   logic              st_mie, st_mpie;
   logic              ie_mtie, ie_meie;
   logic              ip_mtip, ip_meip;
   logic [XLEN-1:0]   mtvec, mscratch, mepc, mcause, mtval;
   logic [2*XLEN-1:0] mcycle, minstret;
   logic [2*XLEN-1:0] mcycle_nxt, minstret_nxt;

   logic [XLEN-1:0]   tvec_base;
   logic [XLEN-1:0]   trap_target;

   assign op = csr_op_e'(csr_bus.csr_op);

   always_comb begin
      old_val = '0;
      mapped  = 1'b1;
      case (csr_bus.csr_addr)
         ADDR_MSTATUS:   begin old_val[3] = st_mie;  old_val[7]  = st_mpie; end
         ADDR_MIE:       begin old_val[7] = ie_mtie; old_val[11] = ie_meie; end
         ADDR_MTVEC:     old_val = mtvec;
         ADDR_MSCRATCH:  old_val = mscratch;
         ADDR_MEPC:      old_val = mepc;
         ADDR_MCAUSE:    old_val = mcause;
         ADDR_MTVAL:     old_val = mtval;
         ADDR_MIP:       begin old_val[7] = ip_mtip; old_val[11] = ip_meip; end
         ADDR_MCYCLE:    old_val = mcycle[XLEN-1:0];
         ADDR_MINSTRET:  old_val = minstret[XLEN-1:0];
         ADDR_MCYCLEH:   old_val = mcycle[2*XLEN-1:XLEN];
         ADDR_MINSTRETH: old_val = minstret[2*XLEN-1:XLEN];
         default:        mapped = 1'b0;
      endcase
   end

   always_comb begin
      case (op)
         OP_WRITE: new_val = csr_bus.csr_w_data;
         OP_SET:   new_val = old_val | csr_bus.csr_w_data;
         OP_CLEAR: new_val = old_val & ~csr_bus.csr_w_data;
         default:  new_val = old_val;
      endcase
   end

   assign csr_bus.csr_r_data  = old_val;
   assign csr_bus.csr_illegal = (op != OP_NONE) && !mapped;

   // Trap and mret both suppress the CSR write, counters included.
   assign wr_en = (op != OP_NONE) && mapped && !trap_en && !mret_en;

   assign irq_pending = st_mie & ((ip_meip & ie_meie) | (ip_mtip & ie_mtie));

   assign tvec_base   = mtvec & ~XLEN'(3);
   assign trap_target = (mtvec[1:0] == 2'b01 && trap_cause[XLEN-1])
                      ? tvec_base + ({1'b0, trap_cause[XLEN-2:0]} << 2)
                      : tvec_base;

   // A written half replaces its incremented value; the other half keeps the
   // full 64-bit increment.
   always_comb begin
      mcycle_nxt   = mcycle + {{(2*XLEN-1){1'b0}}, 1'b1};
      minstret_nxt = minstret + {{(2*XLEN-1){1'b0}}, retire_en};
      if (wr_en) begin
         case (csr_bus.csr_addr)
            ADDR_MCYCLE:    mcycle_nxt[XLEN-1:0]        = new_val;
            ADDR_MCYCLEH:   mcycle_nxt[2*XLEN-1:XLEN]   = new_val;
            ADDR_MINSTRET:  minstret_nxt[XLEN-1:0]      = new_val;
            ADDR_MINSTRETH: minstret_nxt[2*XLEN-1:XLEN] = new_val;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         st_mie         <= 1'b0;
         st_mpie        <= 1'b0;
         ie_mtie        <= 1'b0;
         ie_meie        <= 1'b0;
         ip_mtip        <= 1'b0;
         ip_meip        <= 1'b0;
         mtvec          <= MTVEC_RESET;
         mscratch       <= '0;
         mepc           <= '0;
         mcause         <= '0;
         mtval          <= '0;
         mcycle         <= '0;
         minstret       <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         ip_mtip        <= timer_irq;
         ip_meip        <= ext_irq;
         mcycle         <= mcycle_nxt;
         minstret       <= minstret_nxt;
         redirect_valid <= 1'b0;
         if (trap_en) begin
            st_mpie        <= st_mie;
            st_mie         <= 1'b0;
            mepc           <= trap_pc & ~XLEN'(3);
            mcause         <= trap_cause;
            mtval          <= trap_val;
            redirect_valid <= 1'b1;
            redirect_pc    <= trap_target;
         end else if (mret_en) begin
            st_mie         <= st_mpie;
            st_mpie        <= 1'b1;
            redirect_valid <= 1'b1;
            redirect_pc    <= mepc;
         end else if (wr_en) begin
            case (csr_bus.csr_addr)
               ADDR_MSTATUS:  begin st_mie  <= new_val[3]; st_mpie <= new_val[7];  end
               ADDR_MIE:      begin ie_mtie <= new_val[7]; ie_meie <= new_val[11]; end
               ADDR_MTVEC:    mtvec    <= new_val;
               ADDR_MSCRATCH: mscratch <= new_val;
               ADDR_MEPC:     mepc     <= new_val & ~XLEN'(3);
               ADDR_MCAUSE:   mcause   <= new_val;
               ADDR_MTVAL:    mtval    <= new_val;
               default: ;
            endcase
         end
      end
   end
endmodule

// File: doc/csr_trap_unit.md
CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

Interface
REQ-001 Parameter XLEN, default 32, data width of every CSR and data port; legal values 32 only, other values are out of scope.
REQ-002 Parameter MTVEC_RESET, default 32'h0000_0000, reset value of mtvec.
REQ-003 Ports clock (input, 1) and reset (input, 1): single clock; reset is synchronous and active-high.
REQ-004 csr_addr  input  12  CSR address.
REQ-005 csr_op  input  2  operation: 00 none, 01 write, 10 set bits, 11 clear bits.
REQ-006 csr_w_data  input  XLEN  operand for csr_op.
REQ-007 csr_r_data  output  XLEN  combinational current (pre-update) value at csr_addr; 0 for unknown addresses.
REQ-008 csr_illegal  output  1  combinational; high when csr_op!=00 and csr_addr is unmapped.
REQ-009 trap_en  input  1  synchronous exception or interrupt taken this cycle.
REQ-010 trap_cause  input  XLEN  mcause value; bit XLEN-1 set means interrupt.
REQ-011 trap_pc, trap_val  input  XLEN each  faulting PC and mtval value.
REQ-012 mret_en  input  1  mret retiring this cycle.
REQ-013 retire_en  input  1  one instruction retired this cycle.
REQ-014 ext_irq, timer_irq  input  1 each  level interrupt requests.
REQ-015 irq_pending  output  1  enabled interrupt awaiting service.
REQ-016 redirect_valid  output  1  registered one-cycle pulse; redirect_pc valid.
REQ-017 redirect_pc  output  XLEN  registered fetch target.

Function
REQ-018 Map SHALL be: mstatus 300, mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mtval 343, mip 344, mcycle B00, minstret B02, mcycleh B80, minstreth B82; all others unmapped.
REQ-019 New value SHALL be w_data (01), old|w_data (10), old&~w_data (11); update at next clock edge; unmapped writes ignored.
REQ-020 mstatus SHALL implement only MIE (bit 3) and MPIE (bit 7); other bits read 0, writes dropped.
REQ-021 mie SHALL implement MTIE (bit 7) and MEIE (bit 11) only; mip bits MTIP (7)/MEIP (11) SHALL be timer_irq/ext_irq registered one cycle, read-only.
REQ-022 mepc bits[1:0] SHALL read 0 always; mtvec bits[1:0] mode: 00 direct, 01 vectored, 1x treated as direct.
REQ-023 irq_pending SHALL be combinational MIE & ((MEIP&MEIE)|(MTIP&MTIE)).
REQ-024 Trap: next edge MPIE<=MIE, MIE<=0, mepc<=trap_pc&~3, mcause<=trap_cause, mtval<=trap_val; redirect_valid=1 next cycle.
REQ-025 Trap redirect_pc SHALL be mtvec base (bits[XLEN-1:2]<<2) in direct mode or for exceptions; base+4*trap_cause[XLEN-2:0] for interrupts in vectored mode.
REQ-026 mret: next edge MIE<=MPIE, MPIE<=1, redirect_valid=1, redirect_pc=mepc value before that edge.
REQ-027 Priority same cycle SHALL be trap > mret > CSR write; lower-priority update discarded entirely (including write to unaffected CSRs).
REQ-028 mcycle SHALL be 64-bit, +1 every cycle out of reset, wrap 2^64-1 -> 0.
REQ-029 minstret SHALL be 64-bit, +retire_en each cycle, wraps identically.
REQ-030 CSR write to a counter half SHALL override that cycle's increment for that half; other half keeps its incremented value, no carry from the written half.
REQ-031 redirect_valid SHALL be high exactly one cycle per trap/mret; back-to-back events yield back-to-back pulses.

Reset
REQ-032 On reset: mstatus, mie, mscratch, mepc, mcause, mtval, mip, counters = 0; mtvec = MTVEC_RESET; redirect_valid=0, redirect_pc=0.
REQ-033 Reset asserted mid-operation SHALL win over trap, mret and writes in that cycle; no redirect pulse follows.

Verification
REQ-034 Write 305<-0x80000001, raise trap_en with cause 0x80000007 -> next cycle redirect_pc=0x8000001C, redirect_valid=1 for one cycle, mcause=0x80000007.
REQ-035 Set mstatus MIE, trap with trap_pc=0x1003 -> mepc reads 0x1000, MIE=0, MPIE=1; then mret -> redirect_pc=0x1000, MIE=1, MPIE=1.
REQ-036 MIE=1, MEIE=1, pulse ext_irq -> irq_pending rises one cycle after ext_irq; clearing MEIE via op 11 with 0x800 drops it next cycle.
REQ-037 Write mcycle<=0xFFFFFFFF, mcycleh<=0 -> two cycles later mcycleh=1, mcycle=0 region (carry into high half).
REQ-038 Same cycle trap_en, mret_en, write mscratch<=0x55 -> trap taken, no mret effect, mscratch unchanged.
REQ-039 Op 01 to address 0x7C0 -> csr_illegal=1, csr_r_data=0, no state change.
